// File: rtl/md_unit_controller.sv
// Multi-cycle multiply/divide unit that owns the HI/LO pair. It holds Busy for a fixed latency
// and forms the pipeline Stall from the data-hazard stall and the MD structural stall.
module md_unit_controller #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MDOp_EX,
    input  logic [31:0] A_EX,
    input  logic [31:0] B_EX,
    input  logic        MD_ID,
    input  logic        Stall_HZ,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Stall,
    output logic        o_dbg_state
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt, w_cnt_load;
    logic [31:0] r_hi, r_lo, r_phi, r_plo;
    logic        r_pwr;
    logic [31:0] w_phi, w_plo;
    logic        w_pwr;
    logic        w_is_start, w_start, w_done;
    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_b_safe, w_quo_s, w_rem_s, w_quo_u, w_rem_u;

    assign w_is_start = (MDOp_EX >= OP_MULT) && (MDOp_EX <= OP_DIVU);
    assign w_start    = w_is_start && (r_state == S_IDLE);
    assign w_done     = (r_state == S_RUN) && (r_cnt == 4'd1);

    // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply the signed product.
    assign w_prod_s = {{32{A_EX[31]}}, A_EX} * {{32{B_EX[31]}}, B_EX};
    assign w_prod_u = {32'b0, A_EX} * {32'b0, B_EX};

    // A zero divisor is replaced so the divider never sees it; the result is discarded anyway.
    assign w_b_safe = (B_EX == 32'b0) ? 32'd1 : B_EX;
    assign w_quo_s  = $signed(A_EX) / $signed(w_b_safe);
    assign w_rem_s  = $signed(A_EX) % $signed(w_b_safe);
    assign w_quo_u  = A_EX / w_b_safe;
    assign w_rem_u  = A_EX % w_b_safe;

    always_comb begin
        w_phi      = 32'b0;
        w_plo      = 32'b0;
        w_pwr      = 1'b1;
        w_cnt_load = 4'(MULT_CYCLES);
        case (MDOp_EX)
            OP_MULT:  {w_phi, w_plo} = w_prod_s;
            OP_MULTU: {w_phi, w_plo} = w_prod_u;
            OP_DIV: begin
                w_phi      = w_rem_s;
                w_plo      = w_quo_s;
                w_pwr      = (B_EX != 32'b0);
                w_cnt_load = 4'(DIV_CYCLES);
            end
            OP_DIVU: begin
                w_phi      = w_rem_u;
                w_plo      = w_quo_u;
                w_pwr      = (B_EX != 32'b0);
                w_cnt_load = 4'(DIV_CYCLES);
            end
            default: w_pwr = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_is_start) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = w_cnt_load;
                end
            end
            S_RUN: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'b0;
            r_lo    <= 32'b0;
            r_phi   <= 32'b0;
            r_plo   <= 32'b0;
            r_pwr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_start) begin
                r_phi <= w_phi;
                r_plo <= w_plo;
                r_pwr <= w_pwr;
            end
            // Completion only happens in RUN and moves only happen in IDLE, so they never collide.
            if (w_done && r_pwr) begin
                r_hi <= r_phi;
                r_lo <= r_plo;
            end else if (r_state == S_IDLE) begin
                if (MDOp_EX == OP_MTHI) r_hi <= A_EX;
                if (MDOp_EX == OP_MTLO) r_lo <= A_EX;
            end
        end
    end

    assign HI          = r_hi;
    assign LO          = r_lo;
    assign Busy        = (r_state == S_RUN);
    assign Stall       = Stall_HZ | (MD_ID & (Busy | w_is_start));
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_md_unit_controller.sv
// Directed bench for md_unit_controller: a cycle-level reference model is compared against
// the DUT on every falling edge, plus literal expectations for the documented scenarios.
module tb_md_unit_controller;

    logic        clk;
    logic        reset;
    logic [2:0]  MDOp_EX;
    logic [31:0] A_EX, B_EX;
    logic        MD_ID, Stall_HZ;
    logic [31:0] HI, LO;
    logic        Busy, Stall, o_dbg_state;

    int checks = 0;
    int errors = 0;

    md_unit_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .MDOp_EX(MDOp_EX), .A_EX(A_EX), .B_EX(B_EX),
        .MD_ID(MD_ID), .Stall_HZ(Stall_HZ), .HI(HI), .LO(LO), .Busy(Busy),
        .Stall(Stall), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset = 1'b1; MDOp_EX = 3'd0; A_EX = 32'd0; B_EX = 32'd0;
        MD_ID = 1'b0; Stall_HZ = 1'b0;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pwr;
    int          m_left;
    logic        m_valid = 1'b0;

    task automatic model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl,
                                output logic wr, output int lat);
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        int              da, db;
        rh = 32'd0; rl = 32'd0; wr = 1'b1; lat = 5;
        case (op)
            3'd1: begin
                sa = $signed(a); sb = $signed(b); p = sa * sb;
                rh = p[63:32]; rl = p[31:0];
            end
            3'd2: begin
                ua = a; ub = b; pu = ua * ub;
                rh = pu[63:32]; rl = pu[31:0];
            end
            3'd3: begin
                lat = 10;
                if (b == 0) wr = 1'b0;
                else begin
                    da = $signed(a); db = $signed(b);
                    rl = da / db; rh = da % db;
                end
            end
            default: begin
                lat = 10;
                if (b == 0) wr = 1'b0;
                else begin
                    rl = a / b; rh = a % b;
                end
            end
        endcase
    endtask

    always @(posedge clk) begin
        int lat;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_pwr = 0; m_phi = 0; m_plo = 0;
            m_valid = 1'b1;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && m_pwr) begin
                m_hi = m_phi; m_lo = m_plo;
            end
        end else if (MDOp_EX >= 3'd1 && MDOp_EX <= 3'd4) begin
            model_result(MDOp_EX, A_EX, B_EX, m_phi, m_plo, m_pwr, lat);
            m_left = lat;
        end else if (MDOp_EX == 3'd5) m_hi = A_EX;
        else if (MDOp_EX == 3'd6) m_lo = A_EX;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic exp_busy, exp_stall;
        if (m_valid) begin
            exp_busy  = (m_left > 0);
            exp_stall = Stall_HZ | (MD_ID & (exp_busy | (MDOp_EX >= 3'd1 && MDOp_EX <= 3'd4)));
            check("model_hi", HI, m_hi);
            check("model_lo", LO, m_lo);
            check("model_busy", {31'd0, Busy}, {31'd0, exp_busy});
            check("model_stall", {31'd0, Stall}, {31'd0, exp_stall});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic md, input logic hz, input logic rst);
        @(negedge clk);
        #1;
        MDOp_EX = op; A_EX = a; B_EX = b; MD_ID = md; Stall_HZ = hz; reset = rst;
    endtask

    task automatic count_busy(input logic md, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(3'd0, 32'd0, 32'd0, md, 1'b0, 1'b0);
            if (!Busy) break;
            n++;
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        tick(3'd0, 0, 0, 0, 0, 1);
        tick(3'd0, 0, 0, 0, 0, 0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);

        // signed mult
        tick(3'd1, 32'hFFFFFFFF, 32'h2, 0, 0, 0);
        count_busy(0, n);
        check("mult_busy_cycles", n, 5);
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFFE);

        // unsigned mult, signed div, unsigned div
        tick(3'd2, 32'hFFFFFFFF, 32'h2, 0, 0, 0);
        count_busy(0, n);
        check("multu_busy_cycles", n, 5);
        check("multu_hi", HI, 32'h00000001);
        check("multu_lo", LO, 32'hFFFFFFFE);
        tick(3'd3, 32'hFFFFFFF9, 32'h2, 0, 0, 0);
        count_busy(0, n);
        check("div_busy_cycles", n, 10);
        check("div_lo", LO, 32'hFFFFFFFD);
        check("div_hi", HI, 32'hFFFFFFFF);
        tick(3'd4, 32'd7, 32'd2, 0, 0, 0);
        count_busy(0, n);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);

        // structural stall with mflo held in ID
        tick(3'd3, 32'd100, 32'd7, 1, 0, 0);
        #1 check("stall_start", {31'd0, Stall}, 32'd1);
        count_busy(1, n);
        check("div2_busy_cycles", n, 10);
        check("stall_released", {31'd0, Stall}, 32'd0);
        check("div2_lo", LO, 32'd14);
        check("div2_hi", HI, 32'd2);
        tick(3'd3, 32'd100, 32'd7, 0, 0, 0);
        tick(3'd0, 0, 0, 0, 0, 0);
        #1 check("non_md_no_stall", {31'd0, Stall}, 32'd0);
        tick(3'd0, 0, 0, 0, 1, 0);
        #1 check("hz_only_stall", {31'd0, Stall}, 32'd1);
        count_busy(0, n);

        // divide by zero keeps HI/LO; mthi and starts during RUN are ignored
        tick(3'd5, 32'h11111111, 0, 0, 0, 0);
        tick(3'd6, 32'h22222222, 0, 0, 0, 0);
        tick(3'd3, 32'd55, 32'd0, 0, 0, 0);
        tick(3'd5, 32'h5, 0, 0, 0, 0);
        check("dz_busy_c1", {31'd0, Busy}, 32'd1);
        tick(3'd1, 32'd9, 32'd9, 0, 0, 0);
        count_busy(0, n);
        check("dz_busy_rest", n, 8);
        check("dz_hi_kept", HI, 32'h11111111);
        check("dz_lo_kept", LO, 32'h22222222);

        // reset in the middle of a mult
        tick(3'd1, 32'd6, 32'd7, 0, 0, 0);
        tick(3'd0, 0, 0, 0, 0, 0);
        tick(3'd0, 0, 0, 0, 0, 0);
        tick(3'd0, 0, 0, 0, 0, 1);
        check("pre_reset_busy", {31'd0, Busy}, 32'd1);
        tick(3'd0, 0, 0, 0, 0, 0);
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        for (int i = 0; i < 6; i++) tick(3'd0, 0, 0, 0, 0, 0);
        check("midrst_no_late_lo", LO, 32'd0);
        tick(3'd2, 32'd3, 32'd4, 0, 0, 0);
        count_busy(0, n);
        check("post_rst_multu_cycles", n, 5);
        check("post_rst_multu_lo", LO, 32'd12);

        // back-to-back: multu issued on the edge right after mult completes
        tick(3'd1, 32'hFFFFFFFD, 32'd5, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(3'd0, 0, 0, 0, 0, 0);
            check("b2b_busy_high", {31'd0, Busy}, 32'd1);
        end
        tick(3'd2, 32'h00010000, 32'h00010000, 0, 0, 0);
        check("b2b_gap_busy", {31'd0, Busy}, 32'd0);
        check("b2b_mult_hi", HI, 32'hFFFFFFFF);
        check("b2b_mult_lo", LO, 32'hFFFFFFF1);
        count_busy(0, n);
        check("b2b_multu_cycles", n, 5);
        check("b2b_multu_hi", HI, 32'd1);
        check("b2b_multu_lo", LO, 32'd0);

        tick(3'd0, 0, 0, 0, 0, 0);
        tick(3'd0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit_controller.md
Name: md_unit_controller

Overview:
- Multi-cycle multiply/divide unit with its HI/LO register pair and the sequencing that shares it; sits in the EX stage of the 5-stage pipeline, beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from EX and holds Busy for a fixed latency.
- Raises the MD-structural stall for any HI/LO-class instruction in ID and ORs it with the data-hazard stall to form the pipeline's single Stall.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high after a mult/multu start (legal range 1..15).
DIV_CYCLES, 10, cycles Busy stays high after a div/divu start (legal range 1..15).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
MDOp_EX  input  3  EX op: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
A_EX  input  32  rs operand (forwarded)
B_EX  input  32  rt operand (forwarded)
MD_ID  input  1  instruction in ID is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
Stall_HZ  input  1  stall from the Tuse/Tnew data-hazard logic
HI  output  32  HI register
LO  output  32  LO register
Busy  output  1  operation in flight
Stall  output  1  Stall_HZ | Stall_MD, drives PC/IF-ID hold and ID-EX bubble

Behaviour:
- Reset: synchronous. At a rising edge with reset=1: HI=0, LO=0, Busy=0, state=IDLE, counter=0, pending results cleared. Reset overrides everything, including an operation in flight; that operation is discarded with no HI/LO write.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, 4-bit down-counter cnt.
- Start: MDOp_EX in {001..100} at an edge with state=IDLE.
  - Latch the results into pending registers: {pHI,pLO}.
  - mult: signed 64-bit product of A×B.
  - multu: unsigned 64-bit product.
  - div: pLO = signed A/B (quotient truncated toward zero), pHI = signed A%B (remainder takes the sign of A).
  - divu: pLO/pHI are the unsigned quotient/remainder.
  - Load cnt = MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN: each edge decrements cnt. At the edge where cnt==1: HI<=pHI, LO<=pLO, Busy<=0, go to IDLE.
  - Busy is therefore visible for exactly N cycles after the start edge.
  - The new HI/LO become visible in the same cycle Busy falls.
- Divide by zero (B==0, div or divu): full DIV_CYCLES timing is kept; at completion HI/LO are left unchanged.
- mthi/mtlo:
  - In IDLE, HI<=A_EX (mthi) or LO<=A_EX (mtlo) at the next edge; no Busy.
  - In RUN they are ignored. The ID stall makes this unreachable, and the bench checks that it is ignored.
- MDOp_EX start while RUN: ignored. Also unreachable by construction; checked as a protection case.
- Stall logic:
  - Stall_MD = MD_ID & (Busy | start_in_EX), where start_in_EX = MDOp_EX in {001..100}.
  - Stall = Stall_HZ | Stall_MD. Purely combinational, no added latency.
  - mfhi/mflo in ID are held until Busy=0, so they read the completed HI/LO, which the EX-stage readout takes directly from the HI/LO ports.
- Non-MD instructions in ID never stall on Busy. Independent ALU work continues during RUN.
- MDOp 000/111: no effect.
- Arithmetic: products are computed at full 64-bit width; operands are reinterpreted per signedness; no overflow trap.
- Simultaneous events: reset beats completion. A completion edge and a new start cannot coincide, because a start needs IDLE at the edge; a start can happen on the first edge after completion.

Test Plan:
1. Reset, then mult with A=0xFFFFFFFF, B=0x00000002 -> Busy high for exactly 5 cycles; the cycle it falls, HI=0xFFFFFFFF and LO=0xFFFFFFFE.
2. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles. Then div with A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu with A=7, B=2 -> LO=3, HI=1.
3. Issue div, then mflo in ID during each Busy cycle, with Stall_HZ=0 -> Stall=1 in the start cycle and all 10 Busy cycles, Stall=0 the cycle Busy falls. A non-MD op in ID during Busy -> Stall=0. Stall_HZ=1 alone -> Stall=1.
4. HI=0x11111111 and LO=0x22222222 loaded via mthi/mtlo, then div with B=0 -> Busy 10 cycles, HI/LO still 0x11111111/0x22222222. Then force mthi A=0x5 while Busy -> HI unchanged.
5. Assert reset at Busy cycle 3 of a mult -> next cycle Busy=0, HI=LO=0, and no HI/LO write at the old completion time. A new multu started immediately completes normally.
6. Back-to-back: mult completes, then multu starts on the very next edge -> Busy shows a single 0 cycle between the two runs, and both results are correct in turn.
